regfile_mp: RTL

Parametrised multi-port register file for the MIPS pipeline: configurable width, depth and read-port count, two write ports, optional write-to-read bypass, hardwired zero register, and a per-register pending scoreboard. Decode reads operands and hazard status here; EX/MEM and WB drive the two write ports; issue marks destination registers pending for long-latency producers.

---
 rtl/regfile_mp.sv | 113 +++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports, optional write-to-read bypass,
// hardwired zero register and a per-register pending scoreboard for hazard checks.
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_pending,
    input  logic                    wr0_en,
    input  logic [AW-1:0]           wr0_addr,
    input  logic [WIDTH-1:0]        wr0_data,
    input  logic                    wr1_en,
    input  logic [AW-1:0]           wr1_addr,
    input  logic [WIDTH-1:0]        wr1_data,
    input  logic                    pend_set,
    input  logic [AW-1:0]           pend_addr,
    output logic [AW:0]             pend_count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [AW:0]      pend_count_q;
    logic [AW:0]      pend_count_d;
    logic             wr0_ok;
    logic             wr1_ok;
    logic             pset_ok;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Operations aimed at the hardwired zero register are dropped at the source.
    assign wr0_ok  = wr0_en   && !is_zero(wr0_addr);
    assign wr1_ok  = wr1_en   && !is_zero(wr1_addr);
    assign pset_ok = pend_set && !is_zero(pend_addr);

    always_comb begin
        mem_d  = mem_q;
        pend_d = pend_q;
        if (wr0_ok) begin
            mem_d[wr0_addr]  = wr0_data;
            pend_d[wr0_addr] = 1'b0;
        end
        if (wr1_ok) begin
            mem_d[wr1_addr]  = wr1_data;
            pend_d[wr1_addr] = 1'b0;
        end
        // A new producer supersedes a retiring one to the same register.
        if (pset_ok) begin
            pend_d[pend_addr] = 1'b1;
        end
        pend_count_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            pend_count_d = pend_count_d + {{AW{1'b0}}, pend_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q       <= '0;
            pend_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            pend_q       <= pend_d;
            pend_count_q <= pend_count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [AW-1:0]    ra;
            logic             hit0;
            logic             hit1;
            logic [WIDTH-1:0] val;

            assign ra   = rd_addr[gi*AW +: AW];
            assign hit0 = (BYPASS != 0) && wr0_ok && (wr0_addr == ra);
            assign hit1 = (BYPASS != 0) && wr1_ok && (wr1_addr == ra);

            // wr1 has priority on a double hit, matching the write order.
            always_comb begin
                val = mem_q[ra];
                if (hit1) begin
                    val = wr1_data;
                end else if (hit0) begin
                    val = wr0_data;
                end
                if (!rst || is_zero(ra)) begin
                    val = '0;
                end
            end

            assign rd_data[gi*WIDTH +: WIDTH] = val;
            assign rd_pending[gi] = rst && !is_zero(ra) && pend_q[ra] && !(hit0 || hit1);
        end
    endgenerate

    assign pend_count = rst ? pend_count_q : '0;

endmodule
